// File: rtl/tcnt_cmp.sv
// 8-bit timer counter with 4-bit prescaler, compare-match and overflow flags.
// Optional one-shot halt behaviour is enabled by defining TIMER_ONESHOT_EN.
module tcnt_cmp (
    input  logic       i_clk_sys,
    input  logic       i_rst_n,
    input  logic [7:0] i_tcor,
    input  logic [1:0] i_cks,
    input  logic       i_cclr,
    input  logic       i_cmie,
    input  logic       i_ovie,
    input  logic       i_tcnt_wren,
    input  logic [7:0] i_tcnt_datain,
    input  logic       i_cmf_clr,
    input  logic       i_ovf_clr,
    input  logic       i_oneshot,
    output logic [7:0] o_tcnt,
    output logic       o_cmf,
    output logic       o_ovf,
    output logic       o_irq
);

    logic [3:0] div_q, div_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       cmf_q, cmf_d;
    logic       ovf_q, ovf_d;
    logic       tick;
    logic       match;
    logic       halted;
    logic       cmf_set;
    logic       ovf_set;

    assign tick = (i_cks == 2'b01)
                | ((i_cks == 2'b10) & (div_q[1:0] == 2'b11))
                | ((i_cks == 2'b11) & (div_q == 4'hF));

    assign match = (tcnt_q == i_tcor);

`ifdef TIMER_ONESHOT_EN
    logic halt_q, halt_d;

    assign halted = halt_q;

    // A set in the same cycle as a clear wins, mirroring the flag behaviour.
    always_comb begin
        halt_d = halt_q;
        if (i_cmf_clr | i_tcnt_wren) begin
            halt_d = 1'b0;
        end
        if (cmf_set & i_oneshot) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`else
    logic unused_oneshot;

    assign halted         = 1'b0;
    assign unused_oneshot = i_oneshot;
`endif

    // Software write beats a tick; a clear-by-match from FF is not an overflow.
    always_comb begin
        div_d   = div_q + 4'd1;
        tcnt_d  = tcnt_q;
        cmf_set = 1'b0;
        ovf_set = 1'b0;
        if (i_tcnt_wren) begin
            tcnt_d = i_tcnt_datain;
        end else if (tick & ~halted) begin
            cmf_set = match;
            if (match & i_cclr) begin
                tcnt_d = 8'h00;
            end else begin
                tcnt_d  = tcnt_q + 8'd1;
                ovf_set = (tcnt_q == 8'hFF);
            end
        end
        cmf_d = cmf_set | (cmf_q & ~i_cmf_clr);
        ovf_d = ovf_set | (ovf_q & ~i_ovf_clr);
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            div_q  <= 4'd0;
            tcnt_q <= 8'h00;
            cmf_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            tcnt_q <= tcnt_d;
            cmf_q  <= cmf_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_tcnt = tcnt_q;
    assign o_cmf  = cmf_q;
    assign o_ovf  = ovf_q;
    assign o_irq  = (cmf_q & i_cmie) | (ovf_q & i_ovie);

endmodule

// File: doc/tcnt_cmp.md
# tcnt_cmp

8-bit timer counter (TCNT) with prescaler and compare-match logic for the APB timer: the reader of the timer-constant value. Each prescaled tick advances TCNT and compares it against the 8-bit constant supplied from the constant register. The block sets compare-match and overflow flags and drives a masked interrupt request to the APB timer top.

## Interface
- No parameters. Widths are fixed at 8-bit counter and 4-bit prescaler.
- i_clk_sys  in  1  system clock; all state on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_tcor  in  8  compare constant from the constant register; reset value there is 8'hFF.
- i_cks  in  2  clock select: 00 stop, 01 clk/1, 10 clk/4, 11 clk/16.
- i_cclr  in  1  1 = clear TCNT on compare match.
- i_cmie  in  1  compare-match interrupt enable.
- i_ovie  in  1  overflow interrupt enable.
- i_tcnt_wren  in  1  software write strobe for TCNT.
- i_tcnt_datain  in  8  software write data for TCNT.
- i_cmf_clr  in  1  single-cycle clear of CMF.
- i_ovf_clr  in  1  single-cycle clear of OVF.
- i_oneshot  in  1  one-shot mode request; see Configuration.
- o_tcnt  out  8  current counter value.
- o_cmf  out  1  compare-match flag.
- o_ovf  out  1  overflow flag.
- o_irq  out  1  (o_cmf & i_cmie) | (o_ovf & i_ovie); combinational from the flag registers.

## Operation
- Prescaler `div_cnt[3:0]`:
  - Free-running; increments every cycle and wraps 15->0.
  - tick = (cks==01) | (cks==10 & div_cnt[1:0]==3) | (cks==11 & div_cnt==15).
  - cks==00 gives no ticks; TCNT holds. div_cnt keeps running.
- Tick cycle, when i_tcnt_wren=0 and the counter is not halted:
  - match = (o_tcnt == i_tcor), evaluated on the pre-update value.
  - match & i_cclr: TCNT <= 0. Otherwise TCNT <= TCNT+1, wrapping mod 256.
  - match sets CMF.
  - OVF sets only when TCNT==FF and TCNT actually increments to 00. A clear-by-match from FF does not set OVF.
- Software write (i_tcnt_wren=1): TCNT <= i_tcnt_datain. It has priority over a same-cycle tick. No match or overflow evaluation occurs in that cycle.
- Flag clear: i_cmf_clr / i_ovf_clr clears the flag. A same-cycle set wins over clear, so the flag stays 1.
- Matching is level-compare on ticks only. With cks=00, TCNT==TCOR never sets CMF.
- i_tcor changes take effect at the next tick.
- Reset (i_rst_n=0 at a clock edge), from any state, including mid-count or halted:
  - o_tcnt=8'h00, div_cnt=0, o_cmf=0, o_ovf=0, halt=0, hence o_irq=0.
  - Reset overrides wren, ticks and clears.

## Timing
- Tick or write at edge N: the new o_tcnt, o_cmf and o_ovf are visible after edge N.
- o_irq follows the flags in the same cycle, with no extra register stage.
- Period, counting from 0 with i_cclr=1 and TCOR=T: T+1 ticks per match.
  - clk/1: T+1 cycles.
  - clk/4: 4(T+1) cycles.
- First tick after reset:
  - clk/4: at the edge where div_cnt==3, i.e. the 4th edge after reset release.
  - clk/16: at the 16th edge after reset release.
- cks changes mid-count: no div_cnt reset; the next tick follows the new decode on the running div_cnt.

## Configuration
- Macro TIMER_ONESHOT_EN.
- Defined:
  - A halt register exists.
  - On a tick that sets CMF while i_oneshot=1, halt <= 1, and TCNT still takes its match update (0 if cclr).
  - While halt=1, ticks are ignored: TCNT holds and no flags set.
  - halt clears on i_cmf_clr or i_tcnt_wren.
  - A software write still loads TCNT while halted.
- Not defined:
  - No halt register; i_oneshot is present but ignored.
  - The counter free-runs on every tick.

## Test plan
- Reset: drive i_rst_n=0 for 2 cycles mid-count (TCNT=8'h37, CMF=1) -> next cycle o_tcnt=00, o_cmf=0, o_ovf=0, o_irq=0.
- Clear-on-match: cks=01, cclr=1, tcor=8'h05, cmie=1 -> TCNT sequence 0,1,2,3,4,5,0. CMF and o_irq rise the cycle TCNT returns to 0; period 6 cycles; OVF stays 0.
- Overflow: cks=10, cclr=0, write TCNT=8'hFE, tcor=8'h10, ovie=1 -> FF after 4 more cycles, 00 after 8. OVF=1 and o_irq=1 with TCNT=00; CMF=0.
- Priority: on a tick cycle with TCNT==TCOR=8'h20, assert i_tcnt_wren (data 8'h80) and i_cmf_clr -> TCNT=80, CMF=0. Separately, a CMF set coinciding with i_cmf_clr -> CMF=1.
- Stop: cks=00 with TCNT==TCOR=8'h00 for 50 cycles -> TCNT holds, CMF stays 0.
- One-shot (TIMER_ONESHOT_EN): i_oneshot=1, cclr=1, tcor=3, cks=01 -> CMF sets once and TCNT stays 0 for 20 cycles. i_cmf_clr restarts counting. Without the macro, the same stimulus gives periodic matches every 4 cycles.
